// File: rtl/cdc_handshake_rx_if.sv
// Signal bundle for the destination side of a toggle req/ack clock-domain crossing.
// The slave modport is the receiving endpoint. The master modport is its environment.
interface cdc_handshake_rx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_toggle_async;
  logic [WIDTH-1:0] data_async;
  logic             ack_toggle;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             busy;
  logic             protocol_err;

  modport slave (
    input  req_toggle_async, data_async, rx_ready,
    output ack_toggle, rx_data, rx_valid, busy, protocol_err
  );

  modport master (
    output req_toggle_async, data_async, rx_ready,
    input  ack_toggle, rx_data, rx_valid, busy, protocol_err
  );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination endpoint of a toggle-based req/ack CDC: it synchronises the request,
// captures the source-held word, offers it on valid/ready, and then toggles ack back.
module cdc_handshake_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  cdc_handshake_rx_if.slave   bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_seen_q, req_seen_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   err_q, err_d;
  logic                   req_sync;

  assign req_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.req_toggle_async};
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        // data_async is sampled unsynchronised. The source keeps it stable until ack returns.
        if (req_sync != req_seen_q) begin
          data_d     = bus.data_async;
          req_seen_d = req_sync;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // req_seen is left untouched here, so an early toggle is taken as a new request in IDLE.
        if (req_sync != req_seen_q) err_d = 1'b1;
        if (bus.rx_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign bus.ack_toggle   = ack_q;
  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.busy         = (state_q == HOLD);
  assign bus.protocol_err = err_q;

endmodule
